// File: rtl/arb_pkg.sv
// Shared types for the N-channel memory arbiter: arbitration policy and FSM state.
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_FIXED,
    ARB_RR
  } arb_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    LOCKED
  } arb_state_e;

  // Index width for a channel count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_n_rr_pick.sv
// Round-robin picker: returns the first requesting index at or after ptr, modulo N.
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  // rot[k] is the request of channel (ptr + k) mod N; pos_arr[k] is that channel's index.
  logic [N-1:0] rot;
  logic [W-1:0] pos_arr [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [W:0] pos_raw;
      assign pos_raw     = {1'b0, ptr} + (W+1)'(gi);
      assign pos_arr[gi] = (pos_raw >= (W+1)'(N)) ? W'(pos_raw - (W+1)'(N)) : pos_raw[W-1:0];
      assign rot[gi]     = req[pos_arr[gi]];
    end
  endgenerate

  always_comb begin
    valid = |req;
    idx   = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) idx = pos_arr[k];
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-channel memory arbiter with fixed or round-robin policy, locked (atomic) ownership
// and a zero-latency combinational path from the granted channel to the memory port.
module mem_arbiter_n
  import arb_pkg::*;
#(
  parameter int               N_CH       = 2,
  parameter arb_mode_e        MODE       = ARB_RR,
  parameter logic [N_CH-1:0]  FETCH_MASK = {{(N_CH-1){1'b0}}, 1'b1}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      req_r,
  input  logic [N_CH-1:0]      req_w,
  input  logic [N_CH-1:0]      req_lock,
  input  logic [2*N_CH-1:0]    req_sz,
  input  logic [32*N_CH-1:0]   req_addr,
  input  logic [32*N_CH-1:0]   req_wdata,
  output logic [31:0]          req_rdata,
  output logic [N_CH-1:0]      req_busy,
  output logic                 mem_r,
  output logic                 mem_w,
  output logic                 fetch,
  output logic [1:0]           mem_sz,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_busy
);

  localparam int W = idx_w(N_CH);

  arb_state_e      state_reg, state_next;
  logic [W-1:0]    own_reg, own_next;
  logic [W-1:0]    rr_ptr_reg, rr_ptr_next;

  logic [N_CH-1:0] req_vec;
  logic            rr_valid;
  logic [W-1:0]    rr_idx;
  logic            fix_valid;
  logic [W-1:0]    fix_idx;
  logic            gnt_valid;
  logic [W-1:0]    sel;

  assign req_vec   = req_r | req_w;
  assign req_rdata = mem_rdata;

  rr_pick #(
    .N (N_CH),
    .W (W)
  ) u_rr_pick (
    .req   (req_vec),
    .ptr   (rr_ptr_reg),
    .valid (rr_valid),
    .idx   (rr_idx)
  );

  always_comb begin
    fix_valid = |req_vec;
    fix_idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_vec[k]) fix_idx = W'(k);
    end
  end

  // In BUSY/LOCKED only the owner can be served, and only while it keeps requesting.
  always_comb begin
    sel       = own_reg;
    gnt_valid = 1'b0;
    if (state_reg == IDLE) begin
      sel       = (MODE == ARB_RR) ? rr_idx : fix_idx;
      gnt_valid = (MODE == ARB_RR) ? rr_valid : fix_valid;
    end else begin
      gnt_valid = req_vec[own_reg];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      own_reg    <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      own_reg    <= own_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    own_next    = own_reg;
    rr_ptr_next = rr_ptr_reg;
    if (gnt_valid) begin
      own_next = sel;
      if (mem_busy) begin
        state_next = BUSY;
      end else begin
        state_next = req_lock[sel] ? LOCKED : IDLE;
        if (MODE == ARB_RR) begin
          rr_ptr_next = (sel == W'(N_CH - 1)) ? '0 : sel + 1'b1;
        end
      end
    end else if (state_reg == BUSY) begin
      // owner withdrew mid-access: abandon without completion or pointer advance
      state_next = IDLE;
    end else if (state_reg == LOCKED && !req_lock[own_reg]) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    mem_r     = 1'b0;
    mem_w     = 1'b0;
    fetch     = 1'b0;
    mem_sz    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    req_busy  = req_vec;
    if (!rst_n) begin
      req_busy = '1;
    end else if (gnt_valid) begin
      mem_w          = req_w[sel];
      mem_r          = req_r[sel] & ~req_w[sel];
      mem_sz         = req_sz[2*int'(sel) +: 2];
      mem_addr       = req_addr[32*int'(sel) +: 32];
      mem_wdata      = req_wdata[32*int'(sel) +: 32];
      fetch          = FETCH_MASK[sel];
      req_busy[sel]  = mem_busy;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: a round-robin and a fixed-priority instance share stimulus and
// are checked every cycle against a behavioural model, plus directed literal scenarios.
module tb_mem_arbiter_n;
  import arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_r, req_w, req_lock;
  logic [7:0]   req_sz;
  logic [127:0] req_addr, req_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_busy;

  logic [31:0]  req_rdata_rr, req_rdata_fx;
  logic [3:0]   req_busy_rr, req_busy_fx;
  logic         mem_r_rr, mem_w_rr, fetch_rr, mem_r_fx, mem_w_fx, fetch_fx;
  logic [1:0]   mem_sz_rr, mem_sz_fx;
  logic [31:0]  mem_addr_rr, mem_wdata_rr, mem_addr_fx, mem_wdata_fx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter_n #(.N_CH(4), .MODE(ARB_RR), .FETCH_MASK(4'b0011)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_r(req_r), .req_w(req_w), .req_lock(req_lock),
    .req_sz(req_sz), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdata(req_rdata_rr), .req_busy(req_busy_rr),
    .mem_r(mem_r_rr), .mem_w(mem_w_rr), .fetch(fetch_rr), .mem_sz(mem_sz_rr),
    .mem_addr(mem_addr_rr), .mem_wdata(mem_wdata_rr),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy));

  mem_arbiter_n #(.N_CH(4), .MODE(ARB_FIXED), .FETCH_MASK(4'b0001)) dut_fx (
    .clk(clk), .rst_n(rst_n), .req_r(req_r), .req_w(req_w), .req_lock(req_lock),
    .req_sz(req_sz), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rdata(req_rdata_fx), .req_busy(req_busy_fx),
    .mem_r(mem_r_fx), .mem_w(mem_w_fx), .fetch(fetch_fx), .mem_sz(mem_sz_fx),
    .mem_addr(mem_addr_fx), .mem_wdata(mem_wdata_fx),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy));

  logic [72:0] out_rr, out_fx;
  assign out_rr = {mem_r_rr, mem_w_rr, fetch_rr, mem_sz_rr, mem_addr_rr, mem_wdata_rr, req_busy_rr};
  assign out_fx = {mem_r_fx, mem_w_fx, fetch_fx, mem_sz_fx, mem_addr_fx, mem_wdata_fx, req_busy_fx};

  // phase: 0 = free to arbitrate, 1 = access held by own, 2 = own holds the lock
  typedef struct { int phase; int own; int ptr; } mst_t;
  typedef struct packed {
    logic mr; logic mw; logic f; logic [1:0] sz; logic [31:0] a; logic [31:0] d; logic [3:0] b;
  } exp_t;

  mst_t cur [2];
  mst_t nxt [2];

  task automatic chk(input string nm, input logic [72:0] act, input logic [72:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  function automatic void model(input bit is_rr, input logic [3:0] fm, input mst_t s,
                                output exp_t e, output mst_t ns);
    int w = -1;
    e  = '0;
    ns = s;
    if (!rst_n) begin
      e.b = 4'hF;
      ns  = '{0, 0, 0};
      return;
    end
    if (s.phase == 0) begin
      for (int k = 0; k < 4; k++) begin
        int c = is_rr ? (s.ptr + k) % 4 : k;
        if (w < 0 && (req_r[c] | req_w[c])) w = c;
      end
    end else if (req_r[s.own] | req_w[s.own]) begin
      w = s.own;
    end
    e.b = req_r | req_w;
    if (w >= 0) begin
      e.mw   = req_w[w];
      e.mr   = req_r[w] & ~req_w[w];
      e.sz   = req_sz[2*w +: 2];
      e.a    = req_addr[32*w +: 32];
      e.d    = req_wdata[32*w +: 32];
      e.f    = fm[w];
      e.b[w] = mem_busy;
      ns.own = w;
      if (mem_busy) ns.phase = 1;
      else begin
        ns.phase = req_lock[w] ? 2 : 0;
        if (is_rr) ns.ptr = (w + 1) % 4;
      end
    end else if (s.phase == 1) begin
      ns.phase = 0;
    end else if (s.phase == 2 && !req_lock[s.own]) begin
      ns.phase = 0;
    end
  endfunction

  always @(negedge clk) begin
    exp_t e0, e1;
    mst_t n0, n1;
    model(1'b1, 4'b0011, cur[0], e0, n0);
    model(1'b0, 4'b0001, cur[1], e1, n1);
    nxt[0] = n0;
    nxt[1] = n1;
    chk("model_rr", out_rr, e0);
    chk("model_fx", out_fx, e1);
    chk("rdata", 73'({req_rdata_rr, req_rdata_fx}), 73'({mem_rdata, mem_rdata}));
  end

  always @(posedge clk) begin
    cur[0] = nxt[0];
    cur[1] = nxt[1];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] bexp;
    cur[0] = '{0, 0, 0}; cur[1] = '{0, 0, 0};
    nxt[0] = '{0, 0, 0}; nxt[1] = '{0, 0, 0};
    rst_n = 1'b0; req_r = '0; req_w = '0; req_lock = '0; req_sz = 8'he4;
    req_addr  = {32'h400, 32'h300, 32'h200, 32'h100};
    req_wdata = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    mem_busy = 1'b0; mem_rdata = 32'h1234_5678;

    @(negedge clk);
    chk("reset_rr", out_rr, 73'hF);
    chk("reset_fx", out_fx, 73'hF);
    next_cycle();
    rst_n = 1'b1;

    // all channels request, zero-wait: round-robin walks 0,1,2,3,0
    req_r = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bexp = 4'hF;
      bexp[i % 4] = 1'b0;
      chk("rr_seq_addr", 73'(mem_addr_rr), 73'(32'h100 * (i % 4 + 1)));
      chk("rr_seq_busy", 73'(req_busy_rr), 73'(bexp));
      next_cycle();
    end

    // fixed: ch0 and ch2, three wait cycles, then ch2 after ch0 leaves
    req_r = 4'b0101; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fx_hold_busy", 73'(req_busy_fx), 73'(4'b0101));
      chk("fx_hold_addr", 73'(mem_addr_fx), 73'(32'h100));
      next_cycle();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    chk("fx_complete", 73'({req_busy_fx, mem_addr_fx}), 73'({4'b0100, 32'h100}));
    next_cycle();
    req_r = 4'b0100;
    @(negedge clk);
    chk("fx_next_owner", 73'(mem_addr_fx), 73'(32'h300));
    next_cycle();

    // locked write from ch1 stalls a fetch from ch0 until the lock drops
    rst_n = 1'b0; req_r = '0;
    next_cycle();
    rst_n = 1'b1;
    req_w = 4'b0010; req_lock = 4'b0010;
    req_addr[63:32] = 32'h1000; req_wdata[63:32] = 32'hDEADBEEF;
    @(negedge clk);
    chk("lock_write", 73'({mem_w_fx, fetch_fx, mem_addr_fx, mem_wdata_fx}),
        73'({1'b1, 1'b0, 32'h1000, 32'hDEADBEEF}));
    next_cycle();
    req_w = '0; req_r = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) req_lock = '0;
      @(negedge clk);
      chk("lock_stall", 73'({mem_r_fx, req_busy_fx}), 73'({1'b0, 4'b0001}));
      next_cycle();
    end
    @(negedge clk);
    chk("lock_release", 73'({mem_r_fx, fetch_fx, req_busy_fx, mem_addr_fx}),
        73'({1'b1, 1'b1, 4'b0000, 32'h100}));
    next_cycle();

    // owner ch2 withdraws mid-access: idle, pointer unchanged
    rst_n = 1'b0; req_r = '0;
    next_cycle();
    rst_n = 1'b1;
    req_addr[63:32] = 32'h200;
    req_r = 4'b0100; mem_busy = 1'b1;
    @(negedge clk);
    chk("wd_grant", 73'({mem_r_rr, mem_addr_rr}), 73'({1'b1, 32'h300}));
    next_cycle();
    req_r = '0;
    @(negedge clk);
    chk("wd_drop", 73'({mem_r_rr, mem_w_rr, req_busy_rr}), 73'(0));
    next_cycle();
    req_r = 4'hF; mem_busy = 1'b0;
    @(negedge clk);
    chk("wd_ptr_kept", 73'(mem_addr_rr), 73'(32'h100));
    next_cycle();

    // reset in the middle of an access
    req_r = 4'b1010; mem_busy = 1'b1;
    @(negedge clk);
    chk("rst_pre", 73'(mem_addr_rr), 73'(32'h200));
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid", out_rr, 73'hF);
    next_cycle();
    rst_n = 1'b1; req_r = 4'hF; mem_busy = 1'b0;
    @(negedge clk);
    chk("rst_after", 73'(mem_addr_rr), 73'(32'h100));
    next_cycle();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      for (int c = 0; c < 4; c++) begin
        req_r[c]    = ($urandom_range(0, 2) != 0);
        req_w[c]    = ($urandom_range(0, 3) == 0);
        req_lock[c] = ($urandom_range(0, 5) == 0);
      end
      req_sz    = 8'($urandom);
      req_addr  = {$urandom, $urandom, $urandom, $urandom};
      req_wdata = {$urandom, $urandom, $urandom, $urandom};
      mem_busy  = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      next_cycle();
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
